// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// A three-state FSM (IDLE, RUN, DONE) sequences the operation; the result
// and carry-out are published together only when the last bit is processed.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into a - b (computed as a + ~b + 1, cout=1 meaning no borrow).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             last;
  logic             capture;
  logic [1:0]       fa;

  // One full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic s;
    logic co;
    s  = x ^ y ^ c;
    co = (x & y) | (c & (x ^ y));
    return {co, s};
  endfunction

  assign last    = (cnt == LAST_BIT);
  assign capture = start && (state != RUN);
  assign fa      = full_add(a_sh[0], b_sh[0], carry);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  // State register with asynchronous clear to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start in RUN is deliberately not looked at.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, shift one bit per RUN cycle, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (capture) begin
      cnt  <= '0;
      a_sh <= a;
      acc  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      b_sh  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
`else
      b_sh  <= b;
      carry <= cin;
`endif
    end else if (state == RUN) begin
      cnt   <= cnt + 1'b1;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= {fa[0], acc[WIDTH-1:1]};
      carry <= fa[1];
      if (last) begin
        sum  <= {fa[0], acc[WIDTH-1:1]};
        cout <= fa[1];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): table of directed additions plus
// hand-written sequences for back-to-back, ignored start, reset abort and,
// when SERIAL_ADDER_SUB_EN is defined, subtraction.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] last_sum;
  logic         last_cout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t tbl [8];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Caller has set start=1 at a negedge; the next posedge is edge k.
  // Checks WIDTH busy cycles with held outputs, then the done cycle.
  // Returns positioned at the negedge inside the done cycle.
  task automatic wait_result(input logic [W-1:0] es, input logic ec,
                             input bit disturb, input string nm);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      check({nm, " busy"}, busy, 1'b1);
      check({nm, " done_low"}, done, 1'b0);
      check({nm, " sum_hold"}, sum, last_sum);
      check({nm, " cout_hold"}, cout, last_cout);
      if (disturb) begin
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        start = (i == 2);
        if (i == 2) begin
          a = 8'hFF;
          b = 8'hFF;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    check({nm, " done"}, done, 1'b1);
    check({nm, " busy_low"}, busy, 1'b0);
    check({nm, " sum"}, sum, es);
    check({nm, " cout"}, cout, ec);
    last_sum  = es;
    last_cout = ec;
  endtask

  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
  endtask

  initial begin
    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
    tbl[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    last_sum  = '0;
    last_cout = 1'b0;

    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset sum", sum, 8'h00);
    check("reset cout", cout, 1'b0);
    rst_n = 1'b1;

    // Table-driven single operations, each followed by a done-low check.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      launch(tbl[i].a, tbl[i].b, tbl[i].cin);
      wait_result(tbl[i].s, tbl[i].c, 1'b0, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d done_pulse", i), done, 1'b0);
      check($sformatf("vec%0d idle_busy", i), busy, 1'b0);
    end

    // Back-to-back: second start issued during the done cycle.
    @(negedge clk);
    launch(8'hFF, 8'h01, 1'b0);
    wait_result(8'h00, 1'b1, 1'b0, "b2b_first");
    launch(8'hA5, 8'h5A, 1'b1);
    wait_result(8'h00, 1'b1, 1'b0, "b2b_second");
    @(negedge clk);
    check("b2b done_pulse", done, 1'b0);

    // Nonzero prior result so the hold checks below are meaningful.
    @(negedge clk);
    launch(8'h10, 8'h21, 1'b1);
    wait_result(8'h32, 1'b0, 1'b0, "prime");

    // Start re-pulsed mid-run, operands scrambled every run cycle.
    @(negedge clk);
    launch(8'h3C, 8'h0F, 1'b0);
    wait_result(8'h4B, 1'b0, 1'b1, "ignore_start");
    @(negedge clk);
    check("ignore_start single_done", done, 1'b0);
    check("ignore_start no_rerun", busy, 1'b0);

    // Reset mid-run: outputs clear immediately and no done follows.
    @(negedge clk);
    launch(8'h80, 8'h80, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort sum", sum, 8'h00);
    check("abort cout", cout, 1'b0);
    repeat (2) @(negedge clk);
    check("abort no_done", done, 1'b0);
    last_sum  = '0;
    last_cout = 1'b0;
    rst_n = 1'b1;
    launch(8'h01, 8'h02, 1'b0);
    for (int i = 0; i < 1; i++) begin
      wait_result(8'h03, 1'b0, 1'b0, "after_reset");
    end

`ifdef SERIAL_ADDER_SUB_EN
    @(negedge clk);
    sub = 1'b1;
    launch(8'h05, 8'h07, 1'b1);
    wait_result(8'hFE, 1'b0, 1'b0, "sub_borrow");
    sub = 1'b1;
    launch(8'h07, 8'h05, 1'b0);
    wait_result(8'h02, 1'b1, 1'b0, "sub_noborrow");
    sub = 1'b0;
    launch(8'h07, 8'h05, 1'b1);
    wait_result(8'h0D, 1'b0, 1'b0, "sub_off");
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
